// File: rtl/column_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : column_prefetch_buffer_if
// Brief   : Angle-path, texture-ROM and pixel-read bus of the column prefetch buffer.
// Rev     : 1.0
// ============================================================================
interface column_prefetch_buffer_if #(
    parameter int PX_BITS    = 6,
    parameter int COL_BITS   = 8,
    parameter int DATA_WIDTH = 24
);
    logic [COL_BITS-1:0]         col_in;
    logic [PX_BITS+COL_BITS-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]       rom_data;
    logic [PX_BITS-1:0]          px_num;
    logic [DATA_WIDTH-1:0]       pixel_out;
    logic                        fill_busy;
    logic                        swap_pulse;
    logic [7:0]                  drop_count;

    modport master (
        output col_in, rom_data, px_num,
        input  rom_addr, pixel_out, fill_busy, swap_pulse, drop_count
    );

    modport slave (
        input  col_in, rom_data, px_num,
        output rom_addr, pixel_out, fill_busy, swap_pulse, drop_count
    );
endinterface
`default_nettype wire

// File: rtl/column_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : column_prefetch_buffer
// Brief   : Double-buffered texture column cache; fills the back bank from ROM
//           and swaps banks only on a strip-frame boundary.
// Rev     : 1.0
// ============================================================================
module column_prefetch_buffer #(
    parameter int LED_COUNT   = 52,
    parameter int PX_BITS     = 6,
    parameter int COL_BITS    = 8,
    parameter int DATA_WIDTH  = 24,
    parameter int ROM_LATENCY = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    column_prefetch_buffer_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FILL  = 2'd1;
    localparam logic [1:0] c_ST_READY = 2'd2;

    localparam logic [PX_BITS-1:0] c_LED_COUNT = PX_BITS'(LED_COUNT);
    localparam logic [PX_BITS-1:0] c_LAST_IDX  = PX_BITS'(LED_COUNT - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_front_sel;
    logic                  r_front_valid;
    logic                  r_force_fill;
    logic [COL_BITS-1:0]   r_loaded_col;
    logic [COL_BITS-1:0]   r_target_col;
    logic [PX_BITS-1:0]    r_idx;
    logic [PX_BITS-1:0]    r_prev_px;
    logic [7:0]            r_drop_count;
    logic [DATA_WIDTH-1:0] r_pixel_out;
    logic                  r_pipe_vld [ROM_LATENCY];
    logic [PX_BITS-1:0]    r_pipe_idx [ROM_LATENCY];
    logic [DATA_WIDTH-1:0] r_bank0    [LED_COUNT];
    logic [DATA_WIDTH-1:0] r_bank1    [LED_COUNT];

    logic                  w_boundary;
    logic                  w_col_moved;
    logic                  w_abort;
    logic                  w_issue;
    logic                  w_wr_en;
    logic [PX_BITS-1:0]    w_wr_idx;
    logic                  w_fill_done;
    logic                  w_fill_busy;
    logic                  w_swap;
    logic [DATA_WIDTH-1:0] w_front_px;

    // Out-of-range px_num (>= LED_COUNT) can never complete a boundary.
    assign w_boundary  = (r_prev_px == c_LAST_IDX) && (bus.px_num == '0);
    assign w_col_moved = (bus.col_in != r_target_col);
    assign w_abort     = (r_state == c_ST_FILL) && w_col_moved;
    assign w_issue     = (r_state == c_ST_FILL) && !w_col_moved && (r_idx < c_LED_COUNT);
    assign w_wr_idx    = r_pipe_idx[ROM_LATENCY-1];
    assign w_wr_en     = r_pipe_vld[ROM_LATENCY-1] && !w_abort;
    assign w_fill_done = w_wr_en && (w_wr_idx == c_LAST_IDX);
    assign w_front_px  = r_front_sel ? r_bank1[bus.px_num] : r_bank0[bus.px_num];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_force_fill || (bus.col_in != r_loaded_col)) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                if (!w_abort && w_fill_done) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: begin
                if (w_boundary) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_col_moved) begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_fill_busy = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            c_ST_FILL:  w_fill_busy = 1'b1;
            c_ST_READY: w_swap      = w_boundary;
            default: begin
                w_fill_busy = 1'b0;
                w_swap      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_front_sel   <= 1'b0;
            r_front_valid <= 1'b0;
            r_force_fill  <= 1'b1;
            r_loaded_col  <= '0;
            r_target_col  <= '0;
            r_idx         <= '0;
            r_prev_px     <= '0;
            r_drop_count  <= '0;
        end else begin
            r_prev_px <= bus.px_num;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_state_nxt == c_ST_FILL) begin
                        r_target_col <= bus.col_in;
                        r_idx        <= '0;
                        r_force_fill <= 1'b0;
                    end
                end
                c_ST_FILL: begin
                    if (w_abort) begin
                        r_target_col <= bus.col_in;
                        r_idx        <= '0;
                    end else if (w_issue) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_ST_READY: begin
                    if (w_boundary) begin
                        r_front_sel   <= ~r_front_sel;
                        r_front_valid <= 1'b1;
                        r_loaded_col  <= r_target_col;
                    end else if (w_col_moved) begin
                        if (r_drop_count != 8'hFF) begin
                            r_drop_count <= r_drop_count + 8'd1;
                        end
                        r_target_col <= bus.col_in;
                        r_idx        <= '0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Tracks which issued address the arriving rom_data belongs to; an abort flushes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_idx[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_issue;
            r_pipe_idx[0] <= r_idx;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1] && !w_abort;
                r_pipe_idx[i] <= r_pipe_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_front_sel) begin
                r_bank0[w_wr_idx] <= bus.rom_data;
            end else begin
                r_bank1[w_wr_idx] <= bus.rom_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pixel_out <= '0;
        end else begin
            r_pixel_out <= (r_front_valid && (bus.px_num < c_LED_COUNT)) ? w_front_px : '0;
        end
    end

    assign bus.rom_addr   = {r_idx, r_target_col};
    assign bus.pixel_out  = r_pixel_out;
    assign bus.fill_busy  = w_fill_busy;
    assign bus.swap_pulse = w_swap;
    assign bus.drop_count = r_drop_count;
endmodule
`default_nettype wire

// File: doc/column_prefetch_buffer.md
Name: column_prefetch_buffer

Overview:
- Sits between theta_from_breakbeam/column scaling and neopixel_controller in globe mode.
- On each new texture column, prefetches all LED_COUNT pixels of that column from the texture ROM into a back bank.
- Swaps banks only at a strip-frame boundary, so one WS2812 frame never mixes two columns (no tearing).
- Serves pixels to neopixel_controller with the same 1-cycle read latency the ROM presents.

Parameters:
- LED_COUNT, 52, LEDs per strip; bank depth.
- PX_BITS, 6, width of px_num and LED index.
- COL_BITS, 8, column width; TEX_WIDTH = 2^COL_BITS.
- DATA_WIDTH, 24, GRB pixel width.
- ROM_LATENCY, 1, cycles from rom_addr to valid rom_data.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- col_in  in  COL_BITS  current texture column from the angle path.
- rom_addr  out  PX_BITS+COL_BITS  texture ROM address, {idx, col}.
- rom_data  in  DATA_WIDTH  texture ROM read data.
- px_num  in  PX_BITS  next_px_num from neopixel_controller.
- pixel_out  out  DATA_WIDTH  pixel for px_num, registered.
- fill_busy  out  1  high while in FILL.
- swap_pulse  out  1  one-cycle strobe on bank swap.
- drop_count  out  8  saturating count of completed fills discarded before display.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - state=IDLE, front_sel=0, front_valid=0, force_fill=1.
  - loaded_col=0, target_col=0, idx=0, prev_px=0.
  - Bank RAMs are not reset.
- Storage: two banks (bank0, bank1), each LED_COUNT x DATA_WIDTH. front bank = bank[front_sel]; back bank = the other.
- Frame boundary: prev_px (px_num registered every cycle) == LED_COUNT-1 and px_num == 0.
- Read path, every cycle: pixel_out <= (front_valid && px_num < LED_COUNT) ? front[px_num] : 0. Latency 1 cycle.
- rom_addr = {idx, target_col}. Equivalent to idx*TEX_WIDTH + col; no multiplier.
- IDLE:
  - If force_fill or col_in != loaded_col: target_col<=col_in, idx<=0, force_fill<=0, go to FILL.
- FILL:
  - fill_busy=1.
  - Issue one address per cycle, idx 0..LED_COUNT-1.
  - rom_data for idx k is written to back[k] exactly ROM_LATENCY cycles after issue; use a ROM_LATENCY-deep shift of {valid, idx}.
  - When the write for idx LED_COUNT-1 lands, go to READY. FILL lasts LED_COUNT+ROM_LATENCY cycles.
  - col_in != target_col during FILL: abort. Flush the in-flight pipe (pending writes suppressed), target_col<=col_in, idx<=0, stay in FILL. drop_count unchanged.
- READY:
  - On frame boundary: front_sel<=~front_sel, front_valid<=1, loaded_col<=target_col, swap_pulse=1 for that cycle, go to IDLE.
  - Else if col_in != target_col: drop_count<=sat(drop_count+1), target_col<=col_in, idx<=0, go to FILL.
- Simultaneous events:
  - Boundary and col change in the same READY cycle: swap wins, no drop. IDLE detects the mismatch the next cycle and refills.
  - Boundary during FILL, including the completion cycle: ignored; the swap waits for the next boundary.
- Reads and writes never touch the same bank. Swap takes effect for the read issued in the cycle after swap_pulse.
- px_num >= LED_COUNT: pixel_out=0, and never counts as a boundary source.
- drop_count saturates at 255.
- Async reset mid-FILL: outputs 0 immediately, a fresh fill of col_in starts after release.

Test Plan:
- ROM model rom_data={idx,col} zero-extended; reset released, col_in=0x10:
  - FILL for 53 cycles, rom_addr steps 0x010,0x110,...,0x3310.
  - Then READY, fill_busy=0.
- Continuing, px_num sweeps 0..51 then 0:
  - swap_pulse one cycle at the 51->0 boundary.
  - Next frame px_num=5 -> pixel_out=0x000510 one cycle later.
  - Before the swap, pixel_out=0 for every px_num.
- col_in changes 0x10->0x11 when idx=20 in FILL:
  - rom_addr restarts at 0x011, no stale idx-20 write lands.
  - Displayed px 20 = 0x001411.
- In READY col_in 0x11->0x12 with no boundary:
  - drop_count=1, refill with 0x12.
  - After the next boundary, pixel_out for px 3 = 0x000312.
- Boundary and col_in change on the same cycle in READY:
  - swap_pulse=1 showing the old target, drop_count unchanged.
  - FILL with the new column starts 2 cycles later.
- reset=0 pulse mid-FILL:
  - pixel_out, swap_pulse, fill_busy, drop_count are 0 asynchronously.
  - After release, fill of the current col_in starts on the next cycle.
- px_num=52:
  - pixel_out=0, and no swap when px_num next reads 0.
